// File: rtl/sdram_read.sv
// sdram_read: read-side SDRAM datapath. Opens a row, issues a burst-of-two
// READ, packs the two returned 16-bit words into one 32-bit FIFO entry,
// precharges and repeats at the next address. It also services auto-refresh
// requests while it owns the SDRAM bus. All state changes on the falling edge.
//
// Handshake: the controller grants the bus with en_i. A new access (ACTIVE)
// starts only when en_i is high and fifo_full_i is low at that decision point.
// An access that has started always runs to completion. fifo_wr_o is a
// one-cycle strobe, and fifo_data_o is valid in that same cycle. The FIFO
// cannot stall an in-flight word, so it must keep one entry of slack.
module sdram_read #(
  parameter int T_RCD       = 3,
  parameter int T_RP        = 3,
  parameter int T_RFC       = 7,
  parameter int CAS_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst,
  output logic [2:0]  command_o,
  output logic [11:0] addr_o,
  output logic [1:0]  bank_o,
  output logic [1:0]  data_mask_o,
  input  logic [15:0] data_in_i,
  input  logic        en_i,
  output logic        ready_o,
  input  logic [21:0] address_i,
  input  logic        auto_refresh_i,
  output logic [31:0] fifo_data_o,
  input  logic        fifo_full_i,
  output logic        fifo_wr_o,
  output logic [2:0]  state_o
);

  // SDRAM command encodings {RAS_n, CAS_n, WE_n}
  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_ACT  = 3'b011;
  localparam logic [2:0] CMD_READ = 3'b101;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AR   = 3'b001;

  localparam logic [3:0] RCD_WAIT   = 4'(T_RCD - 1);
  localparam logic [3:0] RP_WAIT    = 4'(T_RP - 1);
  localparam logic [3:0] RFC_WAIT   = 4'(T_RFC - 1);
  localparam logic [3:0] RESET_WAIT = 4'd10;
  localparam logic [1:0] CL_LOAD    = 2'(CAS_LATENCY);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACTIVE    = 3'd1,
    READ_CMD  = 3'd2,
    READ_WAIT = 3'd3,
    READ_LOW  = 3'd4,
    PUSH      = 3'd5,
    PRECHARGE = 3'd6,
    WAIT      = 3'd7
  } state_t;

  state_t      state_q;
  logic [3:0]  delay_q;
  logic [1:0]  cas_q;
  logic [21:0] laddr_q;
  logic        lref_q;
  logic [2:0]  cmd_q;
  logic [11:0] addr_q;
  logic [1:0]  bank_q;
  logic [31:0] fifo_data_q;
  logic        fifo_wr_q;

  // Main FSM: delay counter gates every state; all outputs are registered.
  always_ff @(negedge clk_i) begin
    if (rst) begin
      state_q     <= IDLE;
      delay_q     <= RESET_WAIT;
      cas_q       <= 2'd0;
      laddr_q     <= 22'd0;
      lref_q      <= 1'b0;
      cmd_q       <= CMD_NOP;
      addr_q      <= 12'd0;
      bank_q      <= 2'd0;
      fifo_data_q <= 32'd0;
      fifo_wr_q   <= 1'b0;
    end else begin
      cmd_q     <= CMD_NOP;
      fifo_wr_q <= 1'b0;
      if (delay_q != 4'd0) begin
        delay_q <= delay_q - 4'd1;
      end else begin
        case (state_q)
          IDLE: begin
            if (en_i && !fifo_full_i) begin
              laddr_q <= address_i;
              state_q <= ACTIVE;
            end else if (lref_q) begin
              cmd_q   <= CMD_AR;
              delay_q <= RFC_WAIT;
              lref_q  <= 1'b0;
            end
          end
          ACTIVE: begin
            cmd_q   <= CMD_ACT;
            addr_q  <= laddr_q[19:8];
            bank_q  <= laddr_q[21:20];
            delay_q <= RCD_WAIT;
            state_q <= READ_CMD;
          end
          READ_CMD: begin
            // addr[10] stays low so the row is left open for an explicit PRE
            cmd_q   <= CMD_READ;
            addr_q  <= {4'b0000, laddr_q[7:0]};
            bank_q  <= laddr_q[21:20];
            laddr_q <= laddr_q + 22'd2;
            cas_q   <= CL_LOAD;
            state_q <= READ_WAIT;
          end
          READ_WAIT: begin
            if (cas_q == 2'd1) begin
              fifo_data_q[31:16] <= data_in_i;
              state_q            <= READ_LOW;
            end else begin
              cas_q <= cas_q - 2'd1;
            end
          end
          READ_LOW: begin
            fifo_data_q[15:0] <= data_in_i;
            state_q           <= PUSH;
          end
          PUSH: begin
            fifo_wr_q <= 1'b1;
            state_q   <= PRECHARGE;
          end
          PRECHARGE: begin
            cmd_q   <= CMD_PRE;
            addr_q  <= 12'h400;
            delay_q <= RP_WAIT;
            if (en_i && !fifo_full_i && !lref_q) state_q <= ACTIVE;
            else                                 state_q <= WAIT;
          end
          WAIT: begin
            if (lref_q) begin
              cmd_q   <= CMD_AR;
              delay_q <= RFC_WAIT;
              lref_q  <= 1'b0;
            end else if (en_i && !fifo_full_i) begin
              state_q <= ACTIVE;
            end else if (!en_i) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // A new request wins over the clear from an AR issued in the same cycle.
      if (auto_refresh_i && en_i) lref_q <= 1'b1;
    end
  end

  assign command_o   = cmd_q;
  assign addr_o      = addr_q;
  assign bank_o      = bank_q;
  assign data_mask_o = 2'b00;
  assign fifo_data_o = fifo_data_q;
  assign fifo_wr_o   = fifo_wr_q;
  assign ready_o     = (delay_q == 4'd0) && (state_q == IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read: one instance at CAS latency 2, and one at
// CAS latency 3 for the address-wrap case. Each instance has a small SDRAM
// data model that drives data_in only in the two cycles where the DUT should
// sample it. Scoreboard queues hold the expected ACT rows, READ columns and
// FIFO words.
module tb_sdram_read;

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_ACT  = 3'b011;
  localparam logic [2:0] CMD_READ = 3'b101;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AR   = 3'b001;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (CAS latency 2) ----------------
  logic [2:0]  command;
  logic [11:0] addr;
  logic [1:0]  bank, dm;
  logic [15:0] data_in;
  logic        en, ready, auto_ref, fifo_full, fifo_wr;
  logic [21:0] address;
  logic [31:0] fifo_data;
  logic [2:0]  state;

  sdram_read #(.CAS_LATENCY(2)) u_dut (
    .clk_i(clk), .rst(rst), .command_o(command), .addr_o(addr), .bank_o(bank),
    .data_mask_o(dm), .data_in_i(data_in), .en_i(en), .ready_o(ready),
    .address_i(address), .auto_refresh_i(auto_ref), .fifo_data_o(fifo_data),
    .fifo_full_i(fifo_full), .fifo_wr_o(fifo_wr), .state_o(state)
  );

  // ---------------- DUT (CAS latency 3) ----------------
  logic [2:0]  c3_command;
  logic [11:0] c3_addr;
  logic [1:0]  c3_bank, c3_dm;
  logic [15:0] c3_data_in;
  logic        c3_en, c3_ready, c3_auto_ref, c3_fifo_full, c3_fifo_wr;
  logic [21:0] c3_address;
  logic [31:0] c3_fifo_data;
  logic [2:0]  c3_state;

  sdram_read #(.CAS_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst(rst), .command_o(c3_command), .addr_o(c3_addr), .bank_o(c3_bank),
    .data_mask_o(c3_dm), .data_in_i(c3_data_in), .en_i(c3_en), .ready_o(c3_ready),
    .address_i(c3_address), .auto_refresh_i(c3_auto_ref), .fifo_data_o(c3_fifo_data),
    .fifo_full_i(c3_fifo_full), .fifo_wr_o(c3_fifo_wr), .state_o(c3_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [13:0] exp_act_q[$];
  logic [13:0] exp_rd_q[$];
  logic [31:0] rd_data_q[$];
  int          wr_cyc_q[$];

  logic [31:0] c3_exp_q[$];
  logic [13:0] c3_exp_act_q[$];
  logic [13:0] c3_exp_rd_q[$];
  int          c3_rd_cyc_q[$];
  int          c3_wr_cyc_q[$];

  int pcyc = 0;
  int act_cnt = 0, rd_cnt = 0, pre_cnt = 0, ar_cnt = 0, wr_cnt = 0;
  int last_act = 0, last_rd = 0, last_pre = 0, last_ar = 0, last_wr = 0;
  int c3_act_cnt = 0, c3_wr_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- monitor + SDRAM model, CL=2 instance ----------------
  int          rd_k = -1;
  logic [31:0] rd_word = 32'hDEAD_DEAD;
  always @(posedge clk) begin
    logic [31:0] e;
    pcyc++;
    case (command)
      CMD_ACT: begin
        act_cnt++;
        last_act = pcyc;
        e = (exp_act_q.size() > 0) ? 32'(exp_act_q.pop_front()) : 32'hFFFF_FFFF;
        check_eq("act_bank_row", 32'({bank, addr}), e);
      end
      CMD_READ: begin
        rd_cnt++;
        last_rd = pcyc;
        e = (exp_rd_q.size() > 0) ? 32'(exp_rd_q.pop_front()) : 32'hFFFF_FFFF;
        check_eq("read_bank_col", 32'({bank, addr}), e);
      end
      CMD_PRE: begin
        pre_cnt++;
        last_pre = pcyc;
        check_eq("pre_a10", 32'(addr[10]), 32'd1);
      end
      CMD_AR: begin
        ar_cnt++;
        last_ar = pcyc;
      end
      default: ;
    endcase
    if (fifo_wr) begin
      wr_cnt++;
      last_wr = pcyc;
      wr_cyc_q.push_back(pcyc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check_eq("fifo_data", fifo_data, e);
    end
    // Word k is sampled at falling edge R+2+k; drive it on the rising edge just before.
    if (command == CMD_READ) begin
      rd_k    = 0;
      rd_word = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 32'hDEAD_DEAD;
    end else if (rd_k >= 0) begin
      rd_k++;
    end
    if (rd_k == 1)      data_in = rd_word[31:16];
    else if (rd_k == 2) data_in = rd_word[15:0];
    else                data_in = 16'hDEAD;
    if (rd_k >= 2) rd_k = -1;
  end

  // ---------------- monitor + SDRAM model, CL=3 instance ----------------
  int          c3_k = -1;
  logic [31:0] c3_word = 32'hDEAD_DEAD;
  always @(posedge clk) begin
    logic [31:0] e;
    if (c3_command == CMD_ACT) begin
      c3_act_cnt++;
      e = (c3_exp_act_q.size() > 0) ? 32'(c3_exp_act_q.pop_front()) : 32'hFFFF_FFFF;
      check_eq("cl3_act_bank_row", 32'({c3_bank, c3_addr}), e);
    end
    if (c3_command == CMD_READ) begin
      c3_rd_cyc_q.push_back(pcyc);
      e = (c3_exp_rd_q.size() > 0) ? 32'(c3_exp_rd_q.pop_front()) : 32'hFFFF_FFFF;
      check_eq("cl3_read_bank_col", 32'({c3_bank, c3_addr}), e);
    end
    if (c3_fifo_wr) begin
      c3_wr_cnt++;
      c3_wr_cyc_q.push_back(pcyc);
      e = (c3_exp_q.size() > 0) ? c3_exp_q.pop_front() : 32'hFFFF_FFFF;
      check_eq("cl3_fifo_data", c3_fifo_data, e);
    end
    // Words derived from the column: {C3,col} then {3C,col}.
    if (c3_command == CMD_READ) begin
      c3_k    = 0;
      c3_word = {8'hC3, c3_addr[7:0], 8'h3C, c3_addr[7:0]};
    end else if (c3_k >= 0) begin
      c3_k++;
    end
    if (c3_k == 2)      c3_data_in = c3_word[31:16];
    else if (c3_k == 3) c3_data_in = c3_word[15:0];
    else                c3_data_in = 16'hBAD0;
    if (c3_k >= 3) c3_k = -1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_act(input int target, input string tag);
    int n = 0;
    while (act_cnt < target && n < 200) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(act_cnt), 32'(target));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 200) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(ready), 32'd1);
  endtask

  // Queue one expected transfer: ACT row, READ column, model data and FIFO word.
  task automatic expect_xfer(input logic [1:0] b, input logic [11:0] row,
                             input logic [7:0] col, input logic [31:0] word);
    exp_act_q.push_back({b, row});
    exp_rd_q.push_back({b, 4'h0, col});
    rd_data_q.push_back(word);
    exp_q.push_back(word);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int base_act, base_wr, base_ar, n;
    rst = 1'b1; en = 1'b0; address = 22'd0; auto_ref = 1'b0; fifo_full = 1'b0;
    c3_en = 1'b0; c3_address = 22'd0; c3_auto_ref = 1'b0; c3_fifo_full = 1'b0;
    data_in = 16'hDEAD; c3_data_in = 16'hBAD0;

    // Reset: held for 3 cycles
    tick(3);
    check_eq("rst_command", 32'(command), 32'(CMD_NOP));
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_bank", 32'(bank), 32'd0);
    check_eq("rst_dm", 32'(dm), 32'd0);
    check_eq("rst_fifo_data", fifo_data, 32'd0);
    check_eq("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    tick(9);
    check_eq("ready_at_9", 32'(ready), 32'd0);
    tick(1);
    check_eq("ready_at_10", 32'(ready), 32'd1);

    // Single read: bank 1, row 0x234, column 0x45
    base_act = act_cnt; base_wr = wr_cnt;
    expect_xfer(2'd1, 12'h234, 8'h45, 32'hAAAA_5555);
    address = {2'd1, 12'h234, 8'h45};
    en = 1'b1;
    wait_act(base_act + 1, "single_act_seen");
    en = 1'b0;
    wait_ready("single_back_idle");
    check_eq("single_act_to_read", 32'(last_rd - last_act), 32'd3);
    check_eq("single_read_to_wr", 32'(last_wr - last_rd), 32'd4);
    check_eq("single_read_to_pre", 32'(last_pre - last_rd), 32'd5);
    check_eq("single_wr_count", 32'(wr_cnt - base_wr), 32'd1);

    // Streaming four words: columns 0x00..0x06, one word every 11 cycles
    base_act = act_cnt; base_wr = wr_cnt;
    wr_cyc_q.delete();
    expect_xfer(2'd0, 12'h005, 8'h00, 32'h1111_0001);
    expect_xfer(2'd0, 12'h005, 8'h02, 32'h2222_0002);
    expect_xfer(2'd0, 12'h005, 8'h04, 32'h3333_0003);
    expect_xfer(2'd0, 12'h005, 8'h06, 32'h4444_0004);
    address = {2'd0, 12'h005, 8'h00};
    en = 1'b1;
    wait_act(base_act + 4, "stream_act4_seen");
    en = 1'b0;
    wait_ready("stream_back_idle");
    check_eq("stream_wr_count", 32'(wr_cnt - base_wr), 32'd4);
    for (int i = 1; i < wr_cyc_q.size(); i++)
      check_eq("stream_wr_spacing", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd11);

    // FIFO full raised during the 2nd transfer: that word completes, then stall
    base_act = act_cnt; base_wr = wr_cnt;
    expect_xfer(2'd2, 12'h006, 8'h10, 32'h5A5A_0010);
    expect_xfer(2'd2, 12'h006, 8'h12, 32'h5A5A_0012);
    expect_xfer(2'd2, 12'h006, 8'h14, 32'h5A5A_0014);
    address = {2'd2, 12'h006, 8'h10};
    en = 1'b1;
    wait_act(base_act + 2, "full_act2_seen");
    fifo_full = 1'b1;
    tick(30);
    check_eq("full_no_new_act", 32'(act_cnt - base_act), 32'd2);
    check_eq("full_second_pushed", 32'(wr_cnt - base_wr), 32'd2);
    check_eq("full_state_wait", 32'(state), 32'd7);
    fifo_full = 1'b0;
    wait_act(base_act + 3, "full_resume_act");
    en = 1'b0;
    wait_ready("full_back_idle");
    check_eq("full_wr_count", 32'(wr_cnt - base_wr), 32'd3);

    // Refresh pulse with en high during a read: AR in WAIT after PRE
    base_act = act_cnt; base_ar = ar_cnt;
    expect_xfer(2'd1, 12'h077, 8'h20, 32'hBEEF_0020);
    expect_xfer(2'd1, 12'h077, 8'h22, 32'hBEEF_0022);
    address = {2'd1, 12'h077, 8'h20};
    en = 1'b1;
    wait_act(base_act + 1, "ref_act1_seen");
    auto_ref = 1'b1;
    tick(1);
    auto_ref = 1'b0;
    wait_act(base_act + 2, "ref_act2_seen");
    en = 1'b0;
    check_eq("ref_ar_count", 32'(ar_cnt - base_ar), 32'd1);
    // PRE delay (T_RP-1 = 2) then AR; AR delay (T_RFC-1 = 6), one edge WAIT->ACTIVE, then ACT
    check_eq("ref_pre_to_ar", 32'(last_ar - last_pre), 32'd3);
    check_eq("ref_ar_to_act", 32'(last_act - last_ar), 32'd8);
    wait_ready("ref_back_idle");

    // Refresh pulse with en low is ignored
    base_ar = ar_cnt;
    auto_ref = 1'b1;
    tick(1);
    auto_ref = 1'b0;
    tick(20);
    check_eq("ref_en_low_no_ar", 32'(ar_cnt - base_ar), 32'd0);
    check_eq("ref_en_low_ready", 32'(ready), 32'd1);

    // CAS latency 3 with address wrap 0x3FFFFE -> 0x000000
    c3_exp_act_q.push_back({2'd3, 12'hFFF});
    c3_exp_rd_q.push_back({2'd3, 12'h0FE});
    c3_exp_q.push_back(32'hC3FE_3CFE);
    c3_exp_act_q.push_back({2'd0, 12'h000});
    c3_exp_rd_q.push_back({2'd0, 12'h000});
    c3_exp_q.push_back(32'hC300_3C00);
    c3_address = 22'h3F_FFFE;
    c3_en = 1'b1;
    n = 0;
    while (c3_act_cnt < 2 && n < 200) begin tick(1); n++; end
    check_eq("cl3_act2_seen", 32'(c3_act_cnt), 32'd2);
    c3_en = 1'b0;
    n = 0;
    while (c3_wr_cnt < 2 && n < 200) begin tick(1); n++; end
    check_eq("cl3_wr_count", 32'(c3_wr_cnt), 32'd2);
    for (int i = 0; i < c3_wr_cyc_q.size() && i < c3_rd_cyc_q.size(); i++)
      check_eq("cl3_read_to_wr", 32'(c3_wr_cyc_q[i] - c3_rd_cyc_q[i]), 32'd5);
    n = 0;
    while (!c3_ready && n < 200) begin tick(1); n++; end
    check_eq("cl3_back_idle", 32'(c3_ready), 32'd1);

    // Reset in the middle of a burst: no FIFO write, NOP on the next edge
    base_wr = wr_cnt;
    exp_act_q.push_back({2'd0, 12'h0AB});
    exp_rd_q.push_back({2'd0, 12'h030});
    rd_data_q.push_back(32'h1234_5678);
    address = {2'd0, 12'h0AB, 8'h30};
    en = 1'b1;
    n = rd_cnt;
    while (rd_cnt == n && n < 100000 && pcyc < 5000) tick(1);
    check_eq("midrst_read_seen", 32'(rd_cnt - n), 32'd1);
    rst = 1'b1;
    en = 1'b0;
    tick(1);
    check_eq("midrst_cmd_nop", 32'(command), 32'(CMD_NOP));
    check_eq("midrst_state_idle", 32'(state), 32'd0);
    check_eq("midrst_fifo_wr", 32'(fifo_wr), 32'd0);
    rst = 1'b0;
    tick(12);
    check_eq("midrst_no_write", 32'(wr_cnt - base_wr), 32'd0);
    check_eq("midrst_ready", 32'(ready), 32'd1);
    check_eq("final_dm", 32'(dm), 32'd0);

    // Every queued expectation must have been consumed
    check_eq("exp_q_left", 32'(exp_q.size()), 32'd0);
    check_eq("exp_act_left", 32'(exp_act_q.size()), 32'd0);
    check_eq("exp_rd_left", 32'(exp_rd_q.size()), 32'd0);
    check_eq("cl3_exp_left", 32'(c3_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
